// File: rtl/bram_tx_ctrl.sv
// Circular-buffer controller for the 48-bit TX BRAM: accepts words from the DDR3
// read path and streams them to the UART transmitter least-significant byte first.
module bram_tx_ctrl #(
    parameter int WIDTH_DATA = 48,
    parameter int WIDTH_ADDR = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    input  logic [WIDTH_DATA-1:0] i_wr_data,
    output logic                  o_bram_wr_en,
    output logic [WIDTH_ADDR-1:0] o_bram_waddr,
    output logic [WIDTH_DATA-1:0] o_bram_wdata,
    output logic                  o_bram_rd_en,
    output logic [WIDTH_ADDR-1:0] o_bram_raddr,
    input  logic [WIDTH_DATA-1:0] i_bram_rdata,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic [7:0]            o_tx_byte,
    output logic [WIDTH_ADDR:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty
);
    localparam int DEPTH  = 1 << WIDTH_ADDR;
    localparam int NBYTES = WIDTH_DATA / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(NBYTES - 1);
    localparam logic [WIDTH_ADDR:0] COUNT_FULL = (WIDTH_ADDR + 1)'(DEPTH);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_REQ  = 2'd1;
    localparam logic [1:0] RD_WAIT = 2'd2;
    localparam logic [1:0] SEND    = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [WIDTH_ADDR-1:0] wr_ptr_q, wr_ptr_d;
    logic [WIDTH_ADDR-1:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH_ADDR:0]   count_q, count_d;
    logic [WIDTH_DATA-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  wr_fire;
    logic                  tx_fire;
    logic                  capture;

    assign o_full       = (count_q == COUNT_FULL);
    assign o_empty      = (count_q == '0);
    assign o_count      = count_q;
    assign o_wr_ready   = !o_full && !i_rst;
    assign wr_fire      = i_wr_valid && o_wr_ready;
    assign o_bram_wr_en = wr_fire;
    assign o_bram_waddr = wr_ptr_q;
    assign o_bram_wdata = i_wr_data;
    assign o_bram_rd_en = (state_q == RD_REQ);
    assign o_bram_raddr = rd_ptr_q;
    assign o_tx_valid   = (state_q == SEND);
    assign o_tx_byte    = shift_q[7:0];
    assign tx_fire      = o_tx_valid && i_tx_ready;

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        capture  = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) state_d = RD_REQ;
            end
            RD_REQ: begin
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                // BRAM output is valid now; the slot leaves the count on this edge
                capture  = 1'b1;
                shift_d  = i_bram_rdata;
                rd_ptr_d = rd_ptr_q + WIDTH_ADDR'(1);
                idx_d    = '0;
                state_d  = SEND;
            end
            SEND: begin
                if (tx_fire) begin
                    shift_d = shift_q >> 8;
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) state_d = (count_q != '0) ? RD_REQ : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_fire ? (wr_ptr_q + WIDTH_ADDR'(1)) : wr_ptr_q;
        count_d  = count_q;
        case ({wr_fire, capture})
            2'b10:   count_d = count_q + (WIDTH_ADDR + 1)'(1);
            2'b01:   count_d = count_q - (WIDTH_ADDR + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            shift_q  <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
        end
    end
endmodule

// File: tb/tb_bram_tx_ctrl.sv
// Randomised bench for bram_tx_ctrl: a word-in / byte-out queue model predicts the
// UART byte stream, with directed checks for reset, latency, capacity and collisions.
module tb_bram_tx_ctrl;
    localparam int WD = 48;
    localparam int WA = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic [WD-1:0] wr_data;
    logic          bram_wr_en;
    logic [WA-1:0] bram_waddr;
    logic [WD-1:0] bram_wdata;
    logic          bram_rd_en;
    logic [WA-1:0] bram_raddr;
    logic [WD-1:0] bram_rdata;
    logic          tx_valid;
    logic          tx_ready;
    logic [7:0]    tx_byte;
    logic [WA:0]   count;
    logic          full;
    logic          empty;

    int vectors    = 0;
    int miscompares = 0;
    int n_acc;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic       s_valid, s_ready;
    logic [7:0] s_byte;
    logic [WD-1:0] mem [256];

    always #5 clk = ~clk;

    // 1-cycle registered-read simple dual-port BRAM
    always @(posedge clk) begin
        if (bram_wr_en) mem[bram_waddr] <= bram_wdata;
        if (bram_rd_en) bram_rdata <= mem[bram_raddr];
    end

    bram_tx_ctrl #(.WIDTH_DATA(WD), .WIDTH_ADDR(WA)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_data(wr_data),
        .o_bram_wr_en(bram_wr_en), .o_bram_waddr(bram_waddr), .o_bram_wdata(bram_wdata),
        .o_bram_rd_en(bram_rd_en), .o_bram_raddr(bram_raddr), .i_bram_rdata(bram_rdata),
        .o_tx_valid(tx_valid), .i_tx_ready(tx_ready), .o_tx_byte(tx_byte),
        .o_count(count), .o_full(full), .o_empty(empty)
    );

    // One clock: observe handshakes at the falling edge, return 1ns after the rising edge
    task automatic tick();
        @(negedge clk);
        s_valid = tx_valid;
        s_ready = tx_ready;
        s_byte  = tx_byte;
        if (wr_valid && wr_ready) begin
            n_acc++;
            for (int b = 0; b < WD / 8; b++) exp_q.push_back(wr_data[8*b +: 8]);
        end
        if (tx_valid && tx_ready) got_q.push_back(tx_byte);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int bound, output bit timed_out);
        int n = 0;
        wr_valid = 1'b0;
        tx_ready = 1'b1;
        while (got_q.size() < exp_q.size() && n < bound) begin
            tick();
            n++;
        end
        timed_out = (got_q.size() < exp_q.size());
    endtask

    function automatic logic [WD-1:0] rand_word();
        return {16'($urandom()), 32'($urandom())};
    endfunction

    task automatic clear_model();
        exp_q.delete();
        got_q.delete();
        n_acc = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_valid = 1'b1; wr_data = rand_word(); tx_ready = 1'b1;
        tick(); tick();
        vectors++;
        if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL rst_wr_ready got %b want 0", wr_ready); end
        vectors++;
        if (tx_valid !== 1'b0 || tx_byte !== 8'h00) begin
            miscompares++; $display("FAIL rst_tx got valid=%b byte=%h want 0/00", tx_valid, tx_byte);
        end
        vectors++;
        if (count !== '0 || empty !== 1'b1 || full !== 1'b0) begin
            miscompares++; $display("FAIL rst_occ got count=%0d empty=%b full=%b want 0/1/0", count, empty, full);
        end
        vectors++;
        if (bram_rd_en !== 1'b0) begin miscompares++; $display("FAIL rst_rd_en got %b want 0", bram_rd_en); end
        wr_valid = 1'b0;
        rst = 1'b0;
        clear_model();
        tick();
        vectors++;
        if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_wr_ready got %b want 1", wr_ready); end
    endtask

    task automatic test_single();
        logic [WD-1:0] w;
        logic [7:0] ref6 [6];
        bit to;
        ref6 = '{8'h0F, 8'h0E, 8'h0D, 8'h0C, 8'h0B, 8'h0A};
        w = 48'h0A0B0C0D0E0F;
        clear_model();
        tx_ready = 1'b1; wr_valid = 1'b1; wr_data = w;
        tick();
        wr_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (tx_valid !== 1'b0) begin
                miscompares++; $display("FAIL latency_early edge+%0d got valid=%b want 0", c, tx_valid);
            end
            tick();
        end
        vectors++;
        if (tx_valid !== 1'b1 || tx_byte !== 8'h0F) begin
            miscompares++; $display("FAIL latency_E3 got valid=%b byte=%h want 1/0f", tx_valid, tx_byte);
        end
        drain(50, to);
        vectors++;
        if (to || got_q.size() != 6) begin
            miscompares++; $display("FAIL single_count got %0d bytes want 6", got_q.size());
        end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== ref6[i]) begin
                miscompares++; $display("FAIL single_byte%0d got %h want %h", i, got_q[i], ref6[i]);
            end
        end
        tick();
        vectors++;
        if (empty !== 1'b1 || tx_valid !== 1'b0) begin
            miscompares++; $display("FAIL single_empty got empty=%b valid=%b want 1/0", empty, tx_valid);
        end
    endtask

    task automatic test_capacity();
        bit to;
        clear_model();
        tx_ready = 1'b0; wr_valid = 1'b1;
        for (int c = 0; c < 300; c++) begin
            wr_data = rand_word();
            tick();
        end
        vectors++;
        if (n_acc != 257) begin miscompares++; $display("FAIL cap_accepted got %0d want 257", n_acc); end
        vectors++;
        if (full !== 1'b1 || count !== 9'd256 || wr_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL cap_full got full=%b count=%0d ready=%b want 1/256/0", full, count, wr_ready);
        end
        drain(4000, to);
        vectors++;
        if (to || got_q.size() != 1542) begin
            miscompares++; $display("FAIL cap_bytes got %0d want 1542", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL cap_stream[%0d] got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_stall_toggle();
        logic pv, pr;
        logic [7:0] pb;
        bit to;
        clear_model();
        pv = 1'b0; pr = 1'b0; pb = 8'h00;
        for (int c = 0; c < 500; c++) begin
            wr_valid = ($urandom_range(0, 3) == 0) && (n_acc < 20);
            wr_data  = rand_word();
            tx_ready = 1'($urandom_range(0, 1));
            tick();
            if (pv && !pr) begin
                vectors++;
                if (s_valid !== 1'b1 || s_byte !== pb) begin
                    miscompares++;
                    $display("FAIL stall_hold cycle %0d got valid=%b byte=%h want 1/%h", c, s_valid, s_byte, pb);
                end
            end
            pv = s_valid; pr = s_ready; pb = s_byte;
        end
        drain(1000, to);
        vectors++;
        if (to || got_q.size() != exp_q.size()) begin
            miscompares++; $display("FAIL stall_bytes got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL stall_stream[%0d] got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_wrap();
        int n = 0;
        bit to;
        clear_model();
        tx_ready = 1'b1; wr_valid = 1'b1;
        while (n_acc < 600 && n < 10000) begin
            wr_data = rand_word();
            tick();
            n++;
        end
        wr_valid = 1'b0;
        vectors++;
        if (n_acc != 600) begin miscompares++; $display("FAIL wrap_accept got %0d want 600", n_acc); end
        drain(6000, to);
        vectors++;
        if (to || got_q.size() != 3600) begin
            miscompares++; $display("FAIL wrap_bytes got %0d want 3600", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL wrap_stream[%0d] got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_collision();
        bit to;
        clear_model();
        tx_ready = 1'b1; wr_valid = 1'b1; wr_data = rand_word();
        tick();
        wr_valid = 1'b0;
        tick(); tick();
        vectors++;
        if (count !== 9'd1) begin miscompares++; $display("FAIL coll_before got %0d want 1", count); end
        // the third edge after acceptance is the capture edge of the first word
        wr_valid = 1'b1; wr_data = rand_word();
        tick();
        wr_valid = 1'b0;
        vectors++;
        if (count !== 9'd1 || tx_valid !== 1'b1) begin
            miscompares++; $display("FAIL coll_after got count=%0d valid=%b want 1/1", count, tx_valid);
        end
        drain(100, to);
        vectors++;
        if (to || got_q.size() != 12) begin
            miscompares++; $display("FAIL coll_bytes got %0d want 12", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL coll_stream[%0d] got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        bit to;
        clear_model();
        tx_ready = 1'b0; wr_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            wr_data = rand_word();
            tick();
        end
        wr_valid = 1'b0;
        tx_ready = 1'b1;
        while (got_q.size() < 3 && n < 100) begin
            tick();
            n++;
        end
        tx_ready = 1'b0;
        vectors++;
        if (got_q.size() != 3 || tx_valid !== 1'b1 || tx_byte !== exp_q[3]) begin
            miscompares++;
            $display("FAIL rmid_byte3 got n=%0d valid=%b byte=%h want 3/1/%h", got_q.size(), tx_valid, tx_byte, exp_q[3]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (tx_valid !== 1'b0 || count !== '0 || empty !== 1'b1) begin
            miscompares++;
            $display("FAIL rmid_state got valid=%b count=%0d empty=%b want 0/0/1", tx_valid, count, empty);
        end
        clear_model();
        tx_ready = 1'b1; wr_valid = 1'b1; wr_data = rand_word();
        tick();
        drain(100, to);
        vectors++;
        if (to || got_q.size() != 6) begin
            miscompares++; $display("FAIL rmid_bytes got %0d want 6", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++; $display("FAIL rmid_stream[%0d] got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_data = '0; tx_ready = 1'b0;
        n_acc = 0;
        test_reset();
        test_single();
        test_capacity();
        test_stall_toggle();
        test_wrap();
        test_collision();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
